fold_accumulator: RTL

Folding histogram stage directly downstream of the time/phase calculator. Each detected pulse arrives as a valid-qualified phase bin index, and the block increments a per-bin counter in on-chip RAM to build the folded pulse profile. On request it streams the whole profile out in bin order over a valid/ready interface to the peak-finding and distribution stages. It also clears the profile RAM after reset and on command.

---
 rtl/fold_accumulator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fold_accumulator.sv
// Folding histogram: counts pulse events per phase bin in on-chip RAM,
// streams the folded profile on request and clears it after reset or on command.
module fold_accumulator #(
    parameter int NBINS  = 1024,
    parameter int BIN_W  = 10,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bin_valid,
    input  logic [BIN_W-1:0]  bin_index,
    input  logic              clear_req,
    input  logic              dump_req,
    output logic              busy,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [BIN_W-1:0]  rd_index,
    output logic [CNT_W-1:0]  rd_count,
    output logic              rd_last,
    output logic [CNT_W-1:0]  total_events,
    output logic [DROP_W-1:0] dropped_events
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBINS - 1);
    localparam logic [BIN_W-1:0] PENULT   = BIN_W'(NBINS - 2);

    typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DUMP} state_t;
    state_t state, next_state;

    logic [CNT_W-1:0] mem [NBINS];
    logic [BIN_W-1:0] clr_addr, raddr, waddr;
    logic [CNT_W-1:0] wdata, rdata_p1, base_p1, sum_p1, wdata_p2;
    logic             we, accept, dump_pend;
    logic             vld_p1, vld_p2;
    logic [BIN_W-1:0] bin_p1, bin_p2;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    assign busy   = (state != ACCUM);
    assign accept = bin_valid && (state == ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR: if (clr_addr == LAST_BIN) next_state = ACCUM;
            ACCUM: if (clear_req || dump_req) next_state = DRAIN;
            DRAIN: if (!vld_p1) next_state = dump_pend ? DUMP : CLEAR;
            DUMP:  if (rd_valid && rd_ready && rd_last) next_state = ACCUM;
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr  <= '0;
            dump_pend <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            if (state == CLEAR) clr_addr <= clr_addr + BIN_W'(1);
            if (state == ACCUM) begin
                if (clear_req)     dump_pend <= 1'b0;
                else if (dump_req) dump_pend <= 1'b1;
            end
        end
    end

    // Stage 1 -> 2: RAM read data is stale when the previous event hit the same bin
    always_ff @(posedge clk) begin
        bin_p1   <= bin_index;
        bin_p2   <= bin_p1;
        wdata_p2 <= sum_p1;
    end

    always_comb begin
        base_p1 = (vld_p2 && (bin_p2 == bin_p1)) ? wdata_p2 : rdata_p1;
        sum_p1  = sat_inc_cnt(base_p1);
    end

    always_comb begin
        we    = vld_p1;
        waddr = bin_p1;
        wdata = sum_p1;
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end
    end

    // In DUMP the read port follows the output word so a stall simply re-reads it
    always_comb begin
        raddr = bin_index;
        if (state == DUMP)       raddr = rd_ready ? rd_index + BIN_W'(1) : rd_index;
        else if (state == DRAIN) raddr = '0;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_p1 <= mem[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_index <= '0;
            rd_last  <= 1'b0;
        end else if (state == DRAIN && next_state == DUMP) begin
            rd_valid <= 1'b1;
            rd_index <= '0;
            rd_last  <= 1'b0;
        end else if (state == DUMP && rd_valid && rd_ready) begin
            if (rd_last) rd_valid <= 1'b0;
            rd_index <= rd_index + BIN_W'(1);
            rd_last  <= (rd_index == PENULT);
        end
    end

    assign rd_count = rd_valid ? rdata_p1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_events   <= '0;
            dropped_events <= '0;
        end else begin
            if (state == DRAIN && next_state == CLEAR) total_events <= '0;
            else if (accept)                           total_events <= sat_inc_cnt(total_events);
            if (bin_valid && busy) dropped_events <= sat_inc_drop(dropped_events);
        end
    end

endmodule
